// File: rtl/matrix_result_streamer_pkg.sv
// Shared constants and types for the matrix result streamer.
package la_pkg;
  localparam int DW    = 64;
  localparam int N     = 5;
  localparam int NELEM = N * N;
  localparam int IW    = 5;

  typedef logic [DW-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    CSUM   = 2'd2
  } stream_state_t;
endpackage

// File: rtl/matrix_result_streamer_if.sv
// Valid/ready output stream carrying one matrix element per beat.
interface matrix_result_streamer_if;
  import la_pkg::*;

  elem_t         tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic [IW-1:0] tindex;

  modport master (output tdata, output tvalid, output tlast, output tindex, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tindex, output tready);
endinterface

// File: rtl/matrix_result_streamer_snapshot.sv
// Snapshot register for the whole result matrix plus element select.
// Capturing all N*N elements in one cycle isolates the stream from later
// changes on the core's output bus.
module matrix_snapshot_mux
  import la_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                capture,
  input  logic [NELEM*DW-1:0] m_flat,
  input  logic [IW-1:0]       sel,
  output elem_t               elem
);

  // Element k lives at snap_q[k], matching bits [k*DW +: DW] of m_flat.
  logic [NELEM-1:0][DW-1:0] snap_q;

  // Whole-matrix capture on request; cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       snap_q <= '0;
    else if (capture) snap_q <= m_flat;
  end

  // Combinational element select; out-of-range indices read as zero.
  always_comb begin
    elem = '0;
    if (sel < IW'(NELEM)) elem = snap_q[sel];
  end

endmodule

// File: rtl/matrix_result_streamer.sv
// Streams a snapshot of the 5x5 result matrix out in row-major order over
// a valid/ready interface. Optional trailing XOR checksum beat is compiled
// in with STREAM_CHECKSUM_EN.
module matrix_result_streamer
  import la_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NELEM*DW-1:0] m_flat,
  output logic                busy,
  output logic                drop_err,
  matrix_result_streamer_if.master strm
);

  stream_state_t state_q, state_d;
  logic [IW-1:0] count_q;
  logic          capture;
  logic          xfer;
  logic          last_elem;
  elem_t         elem;

  assign capture   = (state_q == IDLE) && start;
  assign xfer      = strm.tvalid && strm.tready;
  assign last_elem = (count_q == IW'(NELEM - 1));
  assign busy      = (state_q != IDLE);

  matrix_snapshot_mux u_snap (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (capture),
    .m_flat  (m_flat),
    .sel     (count_q),
    .elem    (elem)
  );

`ifdef STREAM_CHECKSUM_EN
  elem_t acc_q;

  // Running XOR of every element that actually transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          acc_q <= '0;
    else if (capture)                    acc_q <= '0;
    else if (state_q == STREAM && xfer)  acc_q <= acc_q ^ elem;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: advance only on handshake; starts are honoured only in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = STREAM;
      STREAM: if (xfer && last_elem) begin
`ifdef STREAM_CHECKSUM_EN
                state_d = CSUM;
`else
                state_d = IDLE;
`endif
              end
`ifdef STREAM_CHECKSUM_EN
      CSUM:   if (xfer) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Element counter: restarts on capture, holds at the last index so it
  // never wraps inside a matrix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       count_q <= '0;
    else if (capture)                                 count_q <= '0;
    else if (state_q == STREAM && xfer && !last_elem) count_q <= count_q + IW'(1);
  end

  // Sticky overrun flag: any start seen while a snapshot is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               drop_err <= 1'b0;
    else if (start && busy)   drop_err <= 1'b1;
  end

  // Stream outputs decode from registered state only, so tvalid never
  // depends on tready and payload holds steady through stalls.
  always_comb begin
    strm.tvalid = 1'b0;
    strm.tdata  = '0;
    strm.tindex = '0;
    strm.tlast  = 1'b0;
    case (state_q)
      STREAM: begin
        strm.tvalid = 1'b1;
        strm.tdata  = elem;
        strm.tindex = count_q;
`ifdef STREAM_CHECKSUM_EN
        strm.tlast  = 1'b0;
`else
        strm.tlast  = last_elem;
`endif
      end
`ifdef STREAM_CHECKSUM_EN
      CSUM: begin
        strm.tvalid = 1'b1;
        strm.tdata  = acc_q;
        strm.tindex = IW'(NELEM);
        strm.tlast  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
